// File: rtl/free_list_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : free_list_pkg
//  Description : Shared rename-stage widths and tag/pointer types.
//  Revision    : 1.0 - initial release
// ============================================================================
package free_list_pkg;

    localparam int PREG_W    = 6;
    localparam int ARCH_REGS = 32;
    localparam int DEPTH     = 32;
    localparam int IDX_W     = $clog2(DEPTH);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PREG_W-1:0] fl_ptr_t;

endpackage
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  Module      : free_list
//  Description : Physical-tag free list, two allocations and two releases per
//                cycle, with checkpoint/restore of the allocation pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module free_list
    import free_list_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req_1,
    input  logic              alloc_req_2,
    output logic [PREG_W-1:0] alloc_data_1,
    output logic [PREG_W-1:0] alloc_data_2,
    output logic              alloc_ok,
    input  logic              release_en_1,
    input  logic              release_en_2,
    input  logic [PREG_W-1:0] release_data_1,
    input  logic [PREG_W-1:0] release_data_2,
    input  logic              take_checkpoint,
    input  logic              single_branch,
    input  logic              dual_branch,
    input  logic              instr_num,
    output logic              current_id,
    input  logic              restore,
    input  logic              restore_id,
    output logic [PREG_W-1:0] free_count
);

    preg_t            r_entry [DEPTH];
    fl_ptr_t          r_head;
    fl_ptr_t          r_tail;
    fl_ptr_t          r_ckp [2];
    logic             r_cur_id;

    fl_ptr_t          w_free;
    fl_ptr_t          w_alloc_n;
    fl_ptr_t          w_rel_n;
    fl_ptr_t          w_h1;
    fl_ptr_t          w_head_all;
    fl_ptr_t          w_rel2_ptr;
    logic [IDX_W-1:0] w_idx0;
    logic [IDX_W-1:0] w_idx1;

    // Wrap bit in the pointers keeps full (32) distinct from empty (0).
    assign w_free     = r_tail - r_head;
    assign w_alloc_n  = fl_ptr_t'(alloc_req_1) + fl_ptr_t'(alloc_req_2);
    assign w_rel_n    = fl_ptr_t'(release_en_1) + fl_ptr_t'(release_en_2);
    assign w_h1       = r_head + fl_ptr_t'(alloc_req_1);
    assign w_head_all = r_head + w_alloc_n;
    assign w_rel2_ptr = r_tail + fl_ptr_t'(release_en_1);

    assign w_idx0 = r_head[IDX_W-1:0];
    assign w_idx1 = w_idx0 + IDX_W'(1);

    // Slot 2 is compacted onto the head entry when slot 1 is idle.
    assign alloc_data_1 = r_entry[w_idx0];
    assign alloc_data_2 = alloc_req_1 ? r_entry[w_idx1] : r_entry[w_idx0];
    assign alloc_ok     = (w_free >= w_alloc_n);
    assign free_count   = w_free;
    assign current_id   = r_cur_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= preg_t'(ARCH_REGS + i);
            end
        end else begin
            if (release_en_1) begin
                r_entry[r_tail[IDX_W-1:0]] <= release_data_1;
            end
            if (release_en_2) begin
                r_entry[w_rel2_ptr[IDX_W-1:0]] <= release_data_2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= fl_ptr_t'(ARCH_REGS);
        end else begin
            r_tail <= r_tail + w_rel_n;
            if (restore) begin
                r_head <= r_ckp[restore_id];
            end else if (alloc_ok) begin
                r_head <= w_head_all;
            end
        end
    end

    // current_id stays in lockstep with the alias table even while restoring;
    // only the snapshot write is dropped in that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ckp[0] <= '0;
            r_ckp[1] <= '0;
            r_cur_id <= 1'b0;
        end else if (take_checkpoint && (single_branch || dual_branch)) begin
            if (!restore) begin
                if (dual_branch) begin
                    r_ckp[r_cur_id]  <= w_h1;
                    r_ckp[~r_cur_id] <= w_head_all;
                end else begin
                    r_ckp[r_cur_id] <= instr_num ? w_head_all : w_h1;
                end
            end
            if (!dual_branch) begin
                r_cur_id <= ~r_cur_id;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, w_free} + {1'b0, w_rel_n}) <= 7'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : tb_free_list
//  Description : Self-checking bench for free_list against a position-based
//                model of the free-tag stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       alloc_req_1, alloc_req_2;
    logic [5:0] alloc_data_1, alloc_data_2;
    logic       alloc_ok;
    logic       release_en_1, release_en_2;
    logic [5:0] release_data_1, release_data_2;
    logic       take_checkpoint, single_branch, dual_branch, instr_num;
    logic       current_id;
    logic       restore, restore_id;
    logic [5:0] free_count;

    int n_pass = 0;
    int n_total = 0;

    free_list dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_req_1    (alloc_req_1),
        .alloc_req_2    (alloc_req_2),
        .alloc_data_1   (alloc_data_1),
        .alloc_data_2   (alloc_data_2),
        .alloc_ok       (alloc_ok),
        .release_en_1   (release_en_1),
        .release_en_2   (release_en_2),
        .release_data_1 (release_data_1),
        .release_data_2 (release_data_2),
        .take_checkpoint(take_checkpoint),
        .single_branch  (single_branch),
        .dual_branch    (dual_branch),
        .instr_num      (instr_num),
        .current_id     (current_id),
        .restore        (restore),
        .restore_id     (restore_id),
        .free_count     (free_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: the free list is an unbounded stream of tags; allocation and
    // release are plain integer positions into it.
    int stream [256];
    int apos, rpos, mcid, mn, mh1, mhall, mfree;
    int mckp [2];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) stream[i] = (i < 32) ? 32 + i : 0;
            apos = 0; rpos = 32; mckp[0] = 0; mckp[1] = 0; mcid = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            mn    = int'(alloc_req_1) + int'(alloc_req_2);
            mh1   = apos + int'(alloc_req_1);
            mhall = apos + mn;
            mfree = rpos - apos;
            if (take_checkpoint && (single_branch || dual_branch)) begin
                if (!restore) begin
                    if (dual_branch) begin
                        mckp[mcid] = mh1; mckp[1 - mcid] = mhall;
                    end else begin
                        mckp[mcid] = instr_num ? mhall : mh1;
                    end
                end
                if (!dual_branch) mcid = 1 - mcid;
            end
            if (restore) apos = mckp[int'(restore_id)];
            else if (mfree >= mn) apos = apos + mn;
            if (release_en_1) begin stream[rpos % 256] = int'(release_data_1); rpos++; end
            if (release_en_2) begin stream[rpos % 256] = int'(release_data_2); rpos++; end
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_valid) begin
            chk("m_free_count", int'(free_count), rpos - apos);
            chk("m_alloc_ok", int'(alloc_ok),
                int'((rpos - apos) >= int'(alloc_req_1) + int'(alloc_req_2)));
            chk("m_current_id", int'(current_id), mcid);
            if (rpos - apos >= 1)
                chk("m_alloc_data_1", int'(alloc_data_1), stream[apos % 256]);
            if (alloc_req_2 && (rpos - apos >= (alloc_req_1 ? 2 : 1)))
                chk("m_alloc_data_2", int'(alloc_data_2),
                    stream[(apos + int'(alloc_req_1)) % 256]);
        end
    end

    task automatic clr();
        alloc_req_1 = 0; alloc_req_2 = 0;
        release_en_1 = 0; release_en_2 = 0;
        release_data_1 = '0; release_data_2 = '0;
        take_checkpoint = 0; single_branch = 0; dual_branch = 0; instr_num = 0;
        restore = 0; restore_id = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1; clr();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic both();
        alloc_req_1 = 1; alloc_req_2 = 1;
    endtask

    initial begin
        clr();
        reset_dut();

        // Reset state and first dual allocation
        #1;
        chk("rst_free", int'(free_count), 32);
        chk("rst_ok", int'(alloc_ok), 1);
        chk("rst_cid", int'(current_id), 0);
        chk("rst_d1", int'(alloc_data_1), 32);
        both(); #1;
        chk("both_d1", int'(alloc_data_1), 32);
        chk("both_d2", int'(alloc_data_2), 33);
        chk("both_ok", int'(alloc_ok), 1);
        tick(); #1;
        chk("both_free", int'(free_count), 30);

        // Slot 2 alone compacts onto head
        reset_dut();
        alloc_req_2 = 1; #1;
        chk("req2_d2", int'(alloc_data_2), 32);
        tick(); #1;
        chk("req2_free", int'(free_count), 31);

        // Exhaustion, stall with a same-cycle release
        repeat (15) begin both(); tick(); end
        #1; chk("near_empty_free", int'(free_count), 1);
        both(); release_en_1 = 1; release_data_1 = 6'd5; #1;
        chk("stall_ok", int'(alloc_ok), 0);
        tick(); #1;
        chk("after_rel_free", int'(free_count), 2);
        both(); #1;
        chk("after_rel_ok", int'(alloc_ok), 1);
        chk("after_rel_d1", int'(alloc_data_1), 63);
        chk("after_rel_d2", int'(alloc_data_2), 5);
        tick(); #1;
        chk("empty_free", int'(free_count), 0);
        alloc_req_1 = 1; #1;
        chk("empty_ok_req", int'(alloc_ok), 0);
        alloc_req_1 = 0; #1;
        chk("empty_ok_noreq", int'(alloc_ok), 1);
        tick();

        // Checkpoints and restores
        reset_dut();
        repeat (2) begin both(); tick(); end
        both(); take_checkpoint = 1; dual_branch = 1;
        tick(); #1;
        chk("dual_cid", int'(current_id), 0);
        chk("dual_free", int'(free_count), 26);
        both(); tick();
        alloc_req_1 = 1; tick(); #1;
        chk("spec_free", int'(free_count), 23);
        restore = 1; restore_id = 0; tick(); #1;
        chk("rs0_free", int'(free_count), 27);
        chk("rs0_d1", int'(alloc_data_1), 37);
        restore = 1; restore_id = 1; tick(); #1;
        chk("rs1_free", int'(free_count), 26);
        chk("rs1_d1", int'(alloc_data_1), 38);
        both(); take_checkpoint = 1; single_branch = 1; instr_num = 0;
        tick(); #1;
        chk("single0_cid", int'(current_id), 1);
        alloc_req_1 = 1; take_checkpoint = 1; single_branch = 1; instr_num = 1;
        tick(); #1;
        chk("single1_cid", int'(current_id), 0);
        restore = 1; restore_id = 0; tick(); #1;
        chk("srs0_d1", int'(alloc_data_1), 39);
        chk("srs0_free", int'(free_count), 25);
        restore = 1; restore_id = 1; tick(); #1;
        chk("srs1_d1", int'(alloc_data_1), 41);
        take_checkpoint = 1; single_branch = 1; restore = 1; restore_id = 1;
        tick(); #1;
        chk("ckp_rs_cid", int'(current_id), 1);
        restore = 1; restore_id = 0; tick(); #1;
        chk("ckp_rs_kept", int'(alloc_data_1), 39);

        // Restore with release and requests in the same cycle
        restore = 1; restore_id = 1; both();
        release_en_1 = 1; release_data_1 = 6'd0;
        release_en_2 = 1; release_data_2 = 6'd1;
        tick(); #1;
        chk("rsrel_free", int'(free_count), 25);
        chk("rsrel_d1", int'(alloc_data_1), 41);

        // Asynchronous reset mid-operation
        #1; rst_n = 1'b0; #1;
        chk("async_free", int'(free_count), 32);
        chk("async_cid", int'(current_id), 0);
        chk("async_d1", int'(alloc_data_1), 32);
        @(posedge clk); #1; rst_n = 1'b1;

        // Steady alloc/release traffic wrapping both pointers
        reset_dut();
        both(); tick();
        for (int j = 0; j < 32; j++) begin
            both();
            release_en_1 = 1; release_data_1 = 6'((4 * j * 5 / 2 + 3) & 63);
            release_en_2 = 1; release_data_2 = 6'(((2 * j + 1) * 5 + 3) & 63);
            release_data_1 = 6'(((2 * j) * 5 + 3) & 63);
            if (j == 15) begin
                #1;
                chk("wrap_d1", int'(alloc_data_1), 3);
                chk("wrap_d2", int'(alloc_data_2), 8);
            end
            tick();
        end
        #1; chk("wrap_free", int'(free_count), 30);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/free_list.md
# free_list

Physical-register free list for the scalar rename stage. It is the supply side of the rename alias table: it hands out up to two free 6-bit physical tags per cycle as new mappings. It reclaims up to two tags per cycle from commit. On a branch it snapshots its allocation pointer using the same checkpoint/restore protocol as the alias table, so a mispredict returns speculatively allocated tags in one cycle.

## Interface
- PREG_W, 6: physical tag width.
- ARCH_REGS, 32: architectural registers; tags 0..31 are mapped at reset.
- DEPTH, 32: list capacity (2^PREG_W − ARCH_REGS).
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- alloc_req_1 / alloc_req_2  in  1  slot 1 / slot 2 requests a tag.
- alloc_data_1 / alloc_data_2  out  6  tag for slot 1 / slot 2 (combinational).
- alloc_ok  out  1  enough free tags for all requested slots.
- release_en_1 / release_en_2  in  1  commit frees a tag.
- release_data_1 / release_data_2  in  6  freed tag.
- take_checkpoint, single_branch, dual_branch, instr_num  in  1 each  checkpoint port, identical semantics to the alias table.
- current_id  out  1  next checkpoint slot.
- restore  in  1  mispredict recovery.
- restore_id  in  1  slot to restore.
- free_count  out  6  free tags, 0..32.

## Operation
- Storage: circular array of DEPTH×6-bit entries; head (alloc) and tail (release) pointers, 6 bits each (5-bit index plus wrap bit).
- free_count = tail − head (mod 64).
- Reset values:
  - entry[i] = 32+i, head = 0, tail = 32.
  - ckp slots 0/1 hold head = 0; current_id = 0.
  - free_count = 32, alloc_ok = 1.
- Allocation:
  - Combinational tag selection: alloc_data_1 = entry[head]. alloc_data_2 = entry[head+1] if alloc_req_1, else entry[head] (compacted).
  - Grant: n = alloc_req_1 + alloc_req_2. alloc_ok = (free_count ≥ n), using the pre-release count; no release bypass.
  - Head update: advances by n only when alloc_ok and !restore. All-or-nothing: a partial grant is never made.
- Release: each enabled port writes its tag at tail (port 1 first), and tail advances by the number of enabled ports. Releases are always accepted, including during restore; commit is older than any branch.
  - Overflow (free_count + releases > DEPTH) is illegal; covered by an assertion only.
- Checkpoint (take_checkpoint, with h0 = head, h1 = head + alloc_req_1):
  - dual_branch: ckp[current_id] ← h1 and ckp[current_id+1] ← head after the full allocation; current_id += 2.
  - single_branch, instr_num = 0: ckp[current_id] ← h1; current_id += 1.
  - single_branch, instr_num = 1: ckp[current_id] ← head after the full allocation; current_id += 1.
  - Neither branch flag set: no effect.
  - Stalled allocation (alloc_ok = 0): upstream does not assert take_checkpoint.
- Restore: head ← ckp[restore_id] next cycle; tail unaffected.
- Lockstep with the alias table: current_id advances on take_checkpoint even when restore is also asserted. The checkpoint data write in that cycle is discarded.

## Timing
- Allocation tags are valid in the same cycle as the request; the pointer update is visible in the next cycle.
- Released tags become allocatable one cycle after release.
- Restore takes 1 cycle; alloc_ok and alloc_data reflect the restored head on the following cycle.
- Wrap-around: index = pointer[4:0]; the wrap bit keeps full (32) distinct from empty (0).
- Reset mid-operation reinitialises all state immediately; ckp contents are don't-care until the first checkpoint except as stated above.

## Structure
- Shared rename package holds:
  - PREG_W, ARCH_REGS, DEPTH;
  - a preg_t typedef (logic [5:0]);
  - a fl_ptr_t typedef (logic [5:0]).
  The alias table uses the same package.
- Single module, no sub-modules; the checkpoint array is 2 × fl_ptr_t.

## Test plan
- Reset, req both → alloc_data_1 = 32, alloc_data_2 = 33, alloc_ok = 1; next cycle free_count = 30.
- alloc_req_2 only, from reset → alloc_data_2 = 32; free_count = 31.
- Allocate 31 tags, then request 2 → alloc_ok = 0, head unchanged. Same cycle release_en_1 = 5 → next cycle free_count = 2, alloc_ok = 1 for 2.
- Dual-branch checkpoint at head = 4 with both requests:
  - ckp0 = 5, ckp1 = 6, current_id = 0 (wrapped).
  - Allocate 3 more, then restore_id = 0 → head = 5, free_count = tail − 5.
- Restore and release same cycle → tail advances, head restored, no allocation that cycle.
- Release 64 tags over time, with matching allocations to wrap both pointers twice → tags return in FIFO order and free_count never exceeds 32.
